// File: rtl/envelope_pkg.sv
// Shared definitions for the envelope shaper: state encoding and the
// default attack/decay/sustain/release constants.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  localparam logic [7:0] DEF_ATTACK_STEP   = 8'd32;
  localparam logic [7:0] DEF_DECAY_STEP    = 8'd8;
  localparam logic [7:0] DEF_SUSTAIN_LEVEL = 8'd192;
  localparam logic [7:0] DEF_RELEASE_STEP  = 8'd16;
  localparam logic [7:0] LEVEL_FULL        = 8'd255;

endpackage

// File: rtl/dffr.sv
// Codebase flip-flop: synchronous active-high reset, no enable.
// Ports: clk, reset, d (WIDTH), q (WIDTH).
module dffr #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else       q <= d;
  end

endmodule

// File: rtl/dffre.sv
// Codebase flip-flop: synchronous active-high reset with load enable.
// Reset wins over enable.
// Ports: clk, reset, en, d (WIDTH), q (WIDTH).
module dffre #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VALUE;
    else if (en) q <= d;
  end

endmodule

// File: rtl/env_scaler.sv
// Registered envelope multiply: scaled = (sample * {0,level}) >>> 8.
// Ports: clk, reset, sample[15:0] (signed), level[7:0], valid in;
//        scaled[15:0] (signed, held between pulses), scaled_valid out.
module env_scaler (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic [7:0]  level,
  input  logic        valid,
  output logic [15:0] scaled,
  output logic        scaled_valid
);

  // 16x9 signed product needs 25 bits; the level is zero-extended so it
  // always acts as a non-negative gain.
  logic signed [24:0] product;
  logic        [15:0] shifted;

  always_comb begin
    product = $signed(sample) * $signed({1'b0, level});
    shifted = product[23:8];
  end

  // Data only loads on a valid pulse so the output holds between samples.
  dffre #(.WIDTH(16)) u_data (
    .clk(clk), .reset(reset), .en(valid), .d(shifted), .q(scaled)
  );

  dffr #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .d(valid), .q(scaled_valid)
  );

endmodule

// File: rtl/envelope_shaper.sv
// ADSR envelope generator plus sample scaler.
// Ports: clk, reset (sync, active high), play_enable, note_start,
//        note_done, beat, sample_in[15:0], sample_in_ready;
//        sample_out[15:0], new_sample_ready, env_level[7:0], env_state[2:0].
//
// Handshake: there is no backpressure. sample_in is valid only in a cycle
// with sample_in_ready=1; exactly one cycle later new_sample_ready pulses
// for one cycle with the scaled sample on sample_out, which then holds.
module envelope_shaper
  import envelope_pkg::*;
#(
  parameter logic [7:0] ATTACK_STEP   = DEF_ATTACK_STEP,
  parameter logic [7:0] DECAY_STEP    = DEF_DECAY_STEP,
  parameter logic [7:0] SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
  parameter logic [7:0] RELEASE_STEP  = DEF_RELEASE_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        note_start,
  input  logic        note_done,
  input  logic        beat,
  input  logic [15:0] sample_in,
  input  logic        sample_in_ready,
  output logic [15:0] sample_out,
  output logic        new_sample_ready,
  output logic [7:0]  env_level,
  output logic [2:0]  env_state
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [7:0] level_q;
  logic [7:0] level_d;
  env_state_e state_cur;

  // 9-bit arithmetic so overflow/underflow shows up in bit 8.
  logic [8:0] attack_sum;
  logic [8:0] decay_diff;
  logic [8:0] release_diff;

  always_comb begin
    state_cur    = env_state_e'(state_q);
    attack_sum   = {1'b0, level_q} + {1'b0, ATTACK_STEP};
    decay_diff   = {1'b0, level_q} - {1'b0, DECAY_STEP};
    release_diff = {1'b0, level_q} - {1'b0, RELEASE_STEP};

    state_d = state_q;
    level_d = level_q;

    // note_start keeps the current level so a retrigger does not click.
    if (note_start) begin
      state_d = ST_ATTACK;
    end else if (note_done && (state_cur == ST_ATTACK ||
                               state_cur == ST_DECAY ||
                               state_cur == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else if (beat) begin
      case (state_cur)
        ST_ATTACK: begin
          if (attack_sum >= {1'b0, LEVEL_FULL}) begin
            level_d = LEVEL_FULL;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[7:0];
          end
        end
        ST_DECAY: begin
          if (decay_diff[8] || decay_diff[7:0] <= SUSTAIN_LEVEL) begin
            level_d = SUSTAIN_LEVEL;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = decay_diff[7:0];
          end
        end
        ST_RELEASE: begin
          if (release_diff[8] || release_diff[7:0] == 8'd0) begin
            level_d = 8'd0;
            state_d = ST_IDLE;
          end else begin
            level_d = release_diff[7:0];
          end
        end
        ST_IDLE:    level_d = 8'd0;
        default:    level_d = level_q;
      endcase
    end
  end

  // play_enable low freezes the whole envelope machine.
  dffre #(.WIDTH(3), .RESET_VALUE(3'(ST_IDLE))) u_state (
    .clk(clk), .reset(reset), .en(play_enable), .d(state_d), .q(state_q)
  );

  dffre #(.WIDTH(8)) u_level (
    .clk(clk), .reset(reset), .en(play_enable), .d(level_d), .q(level_q)
  );

  // The sample path runs whether or not play_enable is set.
  env_scaler u_scaler (
    .clk(clk),
    .reset(reset),
    .sample(sample_in),
    .level(level_q),
    .valid(sample_in_ready),
    .scaled(sample_out),
    .scaled_valid(new_sample_ready)
  );

  assign env_level = level_q;
  assign env_state = state_q;

endmodule
